// File: rtl/exc_pkg.sv
// Shared types and constants for the exc_ctrl exception/interrupt sequencer.
package exc_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2
  } exc_state_t;

  // MIPS ExcCode values written into Cause[6:2]
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

  typedef struct packed {
    logic        badvaddr_en;
    logic [31:0] badvaddr;
    logic        bd;
    logic [4:0]  code;
    logic [31:0] epc;
  } exp_info_t;

  // A delay-slot instruction restarts at its branch, one word earlier.
  function automatic logic [31:0] victim_epc(input logic [31:0] pc, input logic bd);
    return bd ? (pc - 32'd4) : pc;
  endfunction

endpackage

// File: rtl/exc_int_sync.sv
// Two-flop synchronizer for the external interrupt lines (used with EXC_HWINT_SYNC_EN).
module exc_int_sync #(
  parameter int unsigned W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt/ERET sequencer: CP0 write strobe, pipeline flush, fetch redirect.
// Build option: define EXC_HWINT_SYNC_EN to pass hw_int through a 2-flop synchronizer.
module exc_ctrl
  import exc_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEFAULT,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  hw_int,
  output logic [5:0]  cause_ip_hw,
  input  logic [7:0]  cp0_interrupt_flag,
  input  logic        cp0_allow_interrupt,
  input  logic [31:0] cp0_epc,
  input  logic [31:0] cp0_cause,
  input  logic        mem_valid,
  input  logic [31:0] mem_pc,
  input  logic        mem_bd,
  input  logic        mem_exc_valid,
  input  logic [4:0]  mem_exc_code,
  input  logic        mem_badvaddr_en,
  input  logic [31:0] mem_badvaddr,
  input  logic        mem_eret,
  output logic        exp_en,
  output logic        exp_badvaddr_en,
  output logic [31:0] exp_badvaddr,
  output logic        exp_bd,
  output logic [4:0]  exp_code,
  output logic [31:0] exp_epc,
  output logic        exl_clean,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready,
  output logic        busy
);

  localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

  exc_state_t  state_q, state_d;
  logic [3:0]  flush_cnt_q, flush_cnt_d;
  exp_info_t   exp_q, exp_d;
  logic        exp_en_q, exp_en_d;
  logic        exl_clean_q, exl_clean_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  logic ev_int, ev_exc, ev_eret, accept;
  logic unused_cause;

  assign ev_int  = mem_valid & cp0_allow_interrupt & (|cp0_interrupt_flag);
  assign ev_exc  = mem_valid & mem_exc_valid;
  assign ev_eret = mem_valid & mem_eret;
  assign accept  = (state_q == IDLE) & (ev_int | ev_exc | ev_eret);

  assign unused_cause = ^{cp0_cause[30:7], cp0_cause[1:0]};

`ifdef EXC_HWINT_SYNC_EN
  exc_int_sync #(.W(6)) u_int_sync (
    .clk (clk),
    .rst (rst),
    .d_i (hw_int),
    .q_o (cause_ip_hw)
  );
`else
  assign cause_ip_hw = hw_int;
`endif

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // NOTE: defaults first so always_comb never infers a latch.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d     = FLUSH;
          flush_cnt_d = '0;
        end
      end
      FLUSH: begin
        if (flush_cnt_q == FLUSH_LAST) state_d = REDIRECT;
        else                           flush_cnt_d = flush_cnt_q + 4'd1;
      end
      REDIRECT: begin
        if (redirect_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    flush          = (state_q == FLUSH);
    redirect_valid = (state_q == REDIRECT);
    busy           = (state_q != IDLE);
  end

  // Captured payload for CP0 and fetch; interrupts outrank exceptions, which outrank ERET.
  always_comb begin
    exp_d         = exp_q;
    redirect_pc_d = redirect_pc_q;
    exp_en_d      = 1'b0;
    exl_clean_d   = 1'b0;
    if (accept) begin
      exp_en_d = 1'b1;
      if (ev_int) begin
        exp_d.badvaddr_en = 1'b0;
        exp_d.bd          = mem_bd;
        exp_d.code        = EXC_INT;
        exp_d.epc         = victim_epc(mem_pc, mem_bd);
        redirect_pc_d     = EXC_VECTOR;
      end else if (ev_exc) begin
        exp_d.badvaddr_en = mem_badvaddr_en;
        exp_d.badvaddr    = mem_badvaddr;
        exp_d.bd          = mem_bd;
        exp_d.code        = mem_exc_code;
        exp_d.epc         = victim_epc(mem_pc, mem_bd);
        redirect_pc_d     = EXC_VECTOR;
      end else begin
        exl_clean_d       = 1'b1;
        exp_d.badvaddr_en = 1'b0;
        exp_d.bd          = cp0_cause[31];
        exp_d.code        = cp0_cause[6:2];
        exp_d.epc         = cp0_epc;
        redirect_pc_d     = cp0_epc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q         <= '0;
      exp_en_q      <= 1'b0;
      exl_clean_q   <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      exp_q         <= exp_d;
      exp_en_q      <= exp_en_d;
      exl_clean_q   <= exl_clean_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign exp_en          = exp_en_q;
  assign exl_clean       = exl_clean_q;
  assign exp_badvaddr_en = exp_q.badvaddr_en;
  assign exp_badvaddr    = exp_q.badvaddr;
  assign exp_bd          = exp_q.bd;
  assign exp_code        = exp_q.code;
  assign exp_epc         = exp_q.epc;
  assign redirect_pc     = redirect_pc_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed scenarios plus randomized events vs a reference model.
module tb_exc_ctrl;

  localparam logic [31:0] VEC = 32'hBFC0_0380;
  localparam int          FC  = 2;

  typedef struct packed {
    logic        valid;
    logic        allow;
    logic [7:0]  flag;
    logic [31:0] pc;
    logic        bd;
    logic        exc;
    logic [4:0]  code;
    logic        bad_en;
    logic [31:0] bad;
    logic        eret;
    logic [31:0] epc;
    logic [31:0] cause;
  } stim_t;

  typedef struct packed {
    logic        valid;
    logic        is_exc;
    logic [4:0]  code;
    logic [31:0] epc;
    logic        bd;
    logic        bad_en;
    logic [31:0] bad;
    logic        exl;
    logic [31:0] rpc;
  } expect_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  hw_int = '0;
  logic [5:0]  cause_ip_hw;
  logic [7:0]  cp0_interrupt_flag;
  logic        cp0_allow_interrupt;
  logic [31:0] cp0_epc, cp0_cause;
  logic        mem_valid, mem_bd, mem_exc_valid, mem_badvaddr_en, mem_eret;
  logic [31:0] mem_pc, mem_badvaddr;
  logic [4:0]  mem_exc_code;
  logic        exp_en, exp_badvaddr_en, exp_bd, exl_clean, flush, redirect_valid, busy;
  logic [31:0] exp_badvaddr, exp_epc, redirect_pc;
  logic [4:0]  exp_code;
  logic        redirect_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  exc_ctrl #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(FC)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .hw_int              (hw_int),
    .cause_ip_hw         (cause_ip_hw),
    .cp0_interrupt_flag  (cp0_interrupt_flag),
    .cp0_allow_interrupt (cp0_allow_interrupt),
    .cp0_epc             (cp0_epc),
    .cp0_cause           (cp0_cause),
    .mem_valid           (mem_valid),
    .mem_pc              (mem_pc),
    .mem_bd              (mem_bd),
    .mem_exc_valid       (mem_exc_valid),
    .mem_exc_code        (mem_exc_code),
    .mem_badvaddr_en     (mem_badvaddr_en),
    .mem_badvaddr        (mem_badvaddr),
    .mem_eret            (mem_eret),
    .exp_en              (exp_en),
    .exp_badvaddr_en     (exp_badvaddr_en),
    .exp_badvaddr        (exp_badvaddr),
    .exp_bd              (exp_bd),
    .exp_code            (exp_code),
    .exp_epc             (exp_epc),
    .exl_clean           (exl_clean),
    .flush               (flush),
    .redirect_valid      (redirect_valid),
    .redirect_pc         (redirect_pc),
    .redirect_ready      (redirect_ready),
    .busy                (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply(input stim_t s);
    mem_valid           = s.valid;
    cp0_allow_interrupt = s.allow;
    cp0_interrupt_flag  = s.flag;
    mem_pc              = s.pc;
    mem_bd              = s.bd;
    mem_exc_valid       = s.exc;
    mem_exc_code        = s.code;
    mem_badvaddr_en     = s.bad_en;
    mem_badvaddr        = s.bad;
    mem_eret            = s.eret;
    cp0_epc             = s.epc;
    cp0_cause           = s.cause;
  endtask

  function automatic stim_t idle_stim();
    return '0;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.valid  = ($urandom_range(0, 7) != 0);
    s.allow  = $urandom_range(0, 1) == 1;
    s.flag   = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
    s.pc     = $urandom;
    s.bd     = $urandom_range(0, 1) == 1;
    s.exc    = $urandom_range(0, 1) == 1;
    s.code   = 5'($urandom);
    s.bad_en = $urandom_range(0, 1) == 1;
    s.bad    = $urandom;
    s.eret   = $urandom_range(0, 1) == 1;
    s.epc    = $urandom;
    s.cause  = $urandom;
    return s;
  endfunction

  // Reference: what CP0 and fetch should receive for a given MEM-stage situation.
  function automatic expect_t predict(input stim_t s);
    expect_t e = '0;
    if (s.valid && s.allow && s.flag != 8'h00) begin
      e.valid = 1'b1;
      e.code  = 5'd0;
      e.bd    = s.bd;
      e.epc   = s.bd ? s.pc - 32'd4 : s.pc;
      e.rpc   = VEC;
    end else if (s.valid && s.exc) begin
      e.valid  = 1'b1;
      e.is_exc = 1'b1;
      e.code   = s.code;
      e.bd     = s.bd;
      e.epc    = s.bd ? s.pc - 32'd4 : s.pc;
      e.bad_en = s.bad_en;
      e.bad    = s.bad;
      e.rpc    = VEC;
    end else if (s.valid && s.eret) begin
      e.valid = 1'b1;
      e.exl   = 1'b1;
      e.code  = s.cause[6:2];
      e.bd    = s.cause[31];
      e.epc   = s.epc;
      e.rpc   = s.epc;
    end
    return e;
  endfunction

  // Called just after a falling edge; drives s for one cycle and checks the whole sequence.
  task automatic run_event(input string name, input stim_t s, input int ready_delay);
    expect_t e = predict(s);
    stim_t   junk;
    apply(s);
    redirect_ready = (ready_delay == 0);
    @(negedge clk);
    if (!e.valid) begin
      check({name, ":no_event_busy"}, 32'(busy), 32'd0);
      check({name, ":no_event_exp_en"}, 32'(exp_en), 32'd0);
      apply(idle_stim());
      redirect_ready = 1'b0;
      return;
    end
    check({name, ":exp_en"}, 32'(exp_en), 32'd1);
    check({name, ":exl_clean"}, 32'(exl_clean), 32'(e.exl));
    check({name, ":exp_code"}, 32'(exp_code), 32'(e.code));
    check({name, ":exp_epc"}, exp_epc, e.epc);
    check({name, ":exp_bd"}, 32'(exp_bd), 32'(e.bd));
    check({name, ":exp_badvaddr_en"}, 32'(exp_badvaddr_en), 32'(e.bad_en));
    if (e.is_exc) check({name, ":exp_badvaddr"}, exp_badvaddr, e.bad);
    check({name, ":flush_t1"}, 32'(flush), 32'd1);
    check({name, ":busy_t1"}, 32'(busy), 32'd1);
    // Events presented while busy must be dropped.
    junk       = rand_stim();
    junk.valid = 1'b1;
    junk.exc   = 1'b1;
    apply(junk);
    for (int c = 2; c <= FC; c++) begin
      @(negedge clk);
      check({name, ":exp_en_pulse_end"}, 32'(exp_en), 32'd0);
      check({name, ":exl_clean_end"}, 32'(exl_clean), 32'd0);
      check({name, ":flush_hold"}, 32'(flush), 32'd1);
      check({name, ":no_early_redirect"}, 32'(redirect_valid), 32'd0);
      check({name, ":exp_epc_hold"}, exp_epc, e.epc);
    end
    @(negedge clk);
    check({name, ":flush_done"}, 32'(flush), 32'd0);
    check({name, ":redirect_valid"}, 32'(redirect_valid), 32'd1);
    check({name, ":redirect_pc"}, redirect_pc, e.rpc);
    for (int d = 0; d < ready_delay; d++) begin
      @(negedge clk);
      check({name, ":stall_valid"}, 32'(redirect_valid), 32'd1);
      check({name, ":stall_pc"}, redirect_pc, e.rpc);
      check({name, ":stall_busy"}, 32'(busy), 32'd1);
      check({name, ":stall_no_exp_en"}, 32'(exp_en), 32'd0);
    end
    redirect_ready = 1'b1;
    @(negedge clk);
    check({name, ":busy_after_xfer"}, 32'(busy), 32'd0);
    check({name, ":valid_after_xfer"}, 32'(redirect_valid), 32'd0);
    redirect_ready = 1'b0;
    apply(idle_stim());
  endtask

  initial begin
    stim_t s;
    apply(idle_stim());

    #2;
    check("reset:exp_en", 32'(exp_en), 32'd0);
    check("reset:flush", 32'(flush), 32'd0);
    check("reset:redirect_valid", 32'(redirect_valid), 32'd0);
    check("reset:redirect_pc", redirect_pc, 32'd0);
    check("reset:busy", 32'(busy), 32'd0);
    check("reset:exp_epc", exp_epc, 32'd0);
    check("reset:exp_code", 32'(exp_code), 32'd0);
    check("reset:cause_ip_hw", 32'(cause_ip_hw), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    s        = idle_stim();
    s.valid  = 1'b1;
    s.exc    = 1'b1;
    s.code   = 5'd4;
    s.pc     = 32'h8000_0010;
    s.bad_en = 1'b1;
    s.bad    = 32'h13;
    run_event("exception", s, 0);

    s        = idle_stim();
    s.valid  = 1'b1;
    s.allow  = 1'b1;
    s.flag   = 8'h01;
    s.bd     = 1'b1;
    s.pc     = 32'h8000_0104;
    s.exc    = 1'b1;
    s.code   = 5'd10;
    s.bad_en = 1'b1;
    s.bad    = 32'hDEAD_BEEF;
    run_event("ds_interrupt", s, 1);

    s       = idle_stim();
    s.valid = 1'b1;
    s.eret  = 1'b1;
    s.epc   = 32'h8000_2000;
    s.cause = 32'h8000_0030;
    run_event("eret", s, 0);

    s       = idle_stim();
    s.valid = 1'b1;
    s.exc   = 1'b1;
    s.code  = 5'd12;
    s.pc    = 32'h0000_0000;
    s.bd    = 1'b1;
    run_event("stall_wrap", s, 5);

    // Asynchronous reset in the cycle after detection.
    s       = idle_stim();
    s.valid = 1'b1;
    s.exc   = 1'b1;
    s.code  = 5'd8;
    s.pc    = 32'h8000_0400;
    apply(s);
    @(negedge clk);
    check("rst_mid:exp_en_before", 32'(exp_en), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid:exp_en", 32'(exp_en), 32'd0);
    check("rst_mid:flush", 32'(flush), 32'd0);
    check("rst_mid:busy", 32'(busy), 32'd0);
    check("rst_mid:redirect_pc", redirect_pc, 32'd0);
    check("rst_mid:exp_epc", exp_epc, 32'd0);
    apply(idle_stim());
    @(negedge clk);
    rst = 1'b0;
    redirect_ready = 1'b1;
    for (int c = 0; c < FC + 3; c++) begin
      @(negedge clk);
      check("rst_mid:no_redirect", 32'(redirect_valid), 32'd0);
      check("rst_mid:no_exp_en", 32'(exp_en), 32'd0);
    end
    redirect_ready = 1'b0;

    hw_int = 6'b000100;
`ifdef EXC_HWINT_SYNC_EN
    @(negedge clk);
    check("sync:lag1", 32'(cause_ip_hw), 32'd0);
    @(negedge clk);
    check("sync:lag2", 32'(cause_ip_hw), 32'b000100);
`else
    #1;
    check("hwint:comb", 32'(cause_ip_hw), 32'b000100);
    @(negedge clk);
`endif
    hw_int = 6'b000000;

    for (int i = 0; i < 40; i++) begin
      run_event("random", rand_stim(), int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exc_ctrl.md
# exc_ctrl

Exception and interrupt sequencer for the coprocessor-0 register file. Each cycle it arbitrates between pending interrupts, the exception flagged by the MEM-stage instruction, and ERET. It then drives the one-cycle CP0 exception-write strobe, holds the pipeline flush, and hands a redirect PC to fetch through a valid/ready handshake. It sits between the MEM stage, CP0 and the fetch unit.

## Interface
- EXC_VECTOR, 32'hBFC00380, exception/interrupt entry address
- FLUSH_CYCLES, 2, cycles `flush` stays high (1..15)
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- hw_int  in  6  external interrupt lines
- cause_ip_hw  out  6  conditioned hw_int, for Cause[15:10]
- cp0_interrupt_flag  in  8  Status.IM & Cause.IP
- cp0_allow_interrupt  in  1  IE=1, EXL=0, ERL=0
- cp0_epc  in  32  current EPC
- cp0_cause  in  32  current Cause
- mem_valid  in  1  MEM stage holds a valid instruction
- mem_pc  in  32  MEM-stage PC
- mem_bd  in  1  MEM instruction is in a delay slot
- mem_exc_valid  in  1  MEM instruction raised an exception
- mem_exc_code  in  5  its ExcCode
- mem_badvaddr_en  in  1  BadVAddr is to be written
- mem_badvaddr  in  32  faulting address
- mem_eret  in  1  MEM instruction is ERET
- exp_en  out  1  CP0 exception-write strobe
- exp_badvaddr_en  out  1  to CP0
- exp_badvaddr  out  32  to CP0
- exp_bd  out  1  to CP0
- exp_code  out  5  to CP0
- exp_epc  out  32  to CP0
- exl_clean  out  1  1 = clear EXL (ERET)
- flush  out  1  kill IF..MEM
- redirect_valid  out  1  redirect PC offered
- redirect_pc  out  32  new fetch PC
- redirect_ready  in  1  fetch accepts redirect
- busy  out  1  state != IDLE

## Operation
- **FSM states:** IDLE, FLUSH, REDIRECT.
- **Arbitration:** evaluated in IDLE only. Priority order:
  - interrupt: mem_valid & cp0_allow_interrupt & |cp0_interrupt_flag
  - exception: mem_valid & mem_exc_valid
  - ERET: mem_valid & mem_eret
- **Interrupt:**
  - exp_code=0, exp_badvaddr_en=0, exl_clean=0
  - exp_epc = mem_bd ? mem_pc-4 : mem_pc (32-bit wrap)
  - exp_bd = mem_bd
  - redirect_pc = EXC_VECTOR
- **Exception:**
  - as interrupt, but exp_code = mem_exc_code
  - badvaddr fields taken from the mem_* inputs
- **ERET:**
  - exp_en=1, exl_clean=1
  - exp_epc=cp0_epc, exp_code=cp0_cause[6:2], exp_bd=cp0_cause[31], exp_badvaddr_en=0; CP0 contents other than EXL are unchanged
  - redirect_pc = cp0_epc sampled at the detection cycle
- **Transitions:**
  - IDLE→FLUSH on any event
  - FLUSH→REDIRECT after FLUSH_CYCLES cycles
  - REDIRECT→IDLE on redirect_valid & redirect_ready
- **Non-IDLE:** all MEM inputs are ignored; events are dropped, since the pipeline is being flushed.
- **Reset values:** all outputs 0, state IDLE, redirect_pc 0, cause_ip_hw 0.

## Timing
- **Event at cycle T (IDLE):**
  - exp_* fields are registered; exp_en=1 for exactly cycle T+1
  - flush=1 during T+1..T+FLUSH_CYCLES
  - redirect_valid rises at T+FLUSH_CYCLES+1
- **Redirect handshake:** redirect_valid and redirect_pc are held stable until ready. If ready is already high when valid rises, the transfer completes that cycle and busy drops the next cycle.
- **Back-to-back:** a new event is accepted at the earliest in the cycle after the transfer (IDLE).
- **Reset mid-operation:** asynchronous reset returns the block to IDLE immediately. No partial exp_en pulse and no redirect are issued after release.
- **Outside the pulse:** exp_* data outputs hold their last values; only exp_en and exl_clean return to 0.

## Configuration
- EXC_HWINT_SYNC_EN defined: hw_int passes through a 2-flop synchronizer; cause_ip_hw lags hw_int by 2 cycles.
- EXC_HWINT_SYNC_EN undefined: cause_ip_hw = hw_int combinationally (synchronous sources only).

## Structure
- **Package exc_pkg:**
  - state enum exc_state_t {IDLE, FLUSH, REDIRECT}
  - ExcCode constants: INT=0, ADEL=4, ADES=5, SYS=8, BP=9, RI=10, OV=12
  - default vector constant
- **Sub-module exc_int_sync:** 6-bit, 2-flop synchronizer with asynchronous reset, instantiated only under EXC_HWINT_SYNC_EN.
- Flush counter: 4 bits.

## Test plan
- **Exception:** mem_exc_valid, code=4, pc=32'h8000_0010, bd=0, badvaddr=32'h13 → exp_en at T+1 with exp_code=4, exp_epc=32'h8000_0010, badvaddr_en=1; flush 2 cycles; redirect_pc=32'hBFC00380.
- **Delay-slot interrupt:** allow_interrupt=1, flag=8'h01, mem_bd=1, pc=32'h8000_0104 (same cycle as an exception) → interrupt wins; exp_code=0, exp_bd=1, exp_epc=32'h8000_0100.
- **ERET:** cp0_epc=32'h8000_2000, cp0_cause=32'h8000_0030 → exp_en=1, exl_clean=1, exp_code=12, exp_bd=1; redirect_pc=32'h8000_2000.
- **Redirect stall:** redirect_ready held 0 for 5 cycles → redirect_valid and redirect_pc stable; busy=1; a mem_exc_valid during the stall is ignored.
- **Reset mid-flush:** rst asserted at T+1 → all outputs 0 immediately; no redirect after release.
- **Synchronizer (EXC_HWINT_SYNC_EN defined):** hw_int=6'b000100 → cause_ip_hw=6'b000100 two cycles later.
